evt_fifo_push_scheduler: RTL and testbench

EVT_FIFO_PUSH_SCHEDULER -- requirements
Module: evt_fifo_push_scheduler

---
 rtl/evt_fifo_push_scheduler.sv | 141 ++++++++++++++
 tb/tb_evt_fifo_push_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_fifo_push_scheduler.sv
// Round-robin push scheduler: NUM_REQ producers share one event FIFO push port,
// with idle-driven SRAM sleep and a fixed wake-up delay before the next grant.
//
// state  | meaning
// ACTIVE | grants allowed; consecutive idle cycles are counted toward sleep
// SLEEP  | power_sleep_o high; waits for a request or a non-empty FIFO
// WAKE   | SRAM recovering for WAKE_CYCLES cycles; no grants
module evt_fifo_push_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic                                 fifo_full_i,
  input  logic                                 fifo_empty_i,
  output logic                                 fifo_push_o,
  output logic [DATA_WIDTH-1:0]                fifo_data_o,
  output logic                                 power_sleep_o,
  output logic [$clog2(NUM_REQ)-1:0]           grant_idx_o
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int SW      = IW + 1;
  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NUM_REQ - 1);
  localparam logic [SW-1:0] NUM_REQ_W = SW'(NUM_REQ);

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   idle_cnt_q;
  logic [CW-1:0]   wake_cnt_q;
  logic            power_sleep_q;

  logic            grant_found;
  logic [IW-1:0]   grant_sel;
  logic [SW-1:0]   scan_sum;
  logic [IW-1:0]   scan_idx;
  logic            grant_en;
  logic            idle_now;
  logic            wake_now;

  // Scan from the priority pointer upward, wrapping modulo NUM_REQ (not 2**IW).
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr_q} + SW'(i);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[IW-1:0];
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_sel   = scan_idx;
      end
    end
  end

  // rst_ni gates the combinational grant so nothing is pushed while held in reset.
  assign grant_en = rst_ni && (state_q == ACTIVE) && !fifo_full_i && grant_found;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = (grant_sel == PTR_LAST) ? '0 : grant_sel + IW'(1);
    end
  end

  assign idle_now = ~|req_valid_i & fifo_empty_i;
  assign wake_now = |req_valid_i | ~fifo_empty_i;

  assign req_ready_o   = grant_en ? (NUM_REQ'(1) << grant_sel) : '0;
  assign fifo_push_o   = grant_en;
  assign fifo_data_o   = grant_en ? req_data_i[grant_sel] : '0;
  assign grant_idx_o   = grant_en ? grant_sel : '0;
  assign power_sleep_o = power_sleep_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ACTIVE;
      ptr_q         <= '0;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      power_sleep_q <= 1'b0;
    end else if (flush_i) begin
      // Flush restarts the counters but never moves the FSM.
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        ACTIVE: begin
          if (!idle_now) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_q    <= '0;
            state_q       <= SLEEP;
            power_sleep_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + CW'(1);
          end
        end
        SLEEP: begin
          if (wake_now) begin
            wake_cnt_q    <= '0;
            state_q       <= WAKE;
            power_sleep_q <= 1'b0;
          end
        end
        WAKE: begin
          if (wake_cnt_q == WAKE_LAST) begin
            wake_cnt_q <= '0;
            state_q    <= ACTIVE;
          end else begin
            wake_cnt_q <= wake_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q       <= ACTIVE;
          power_sleep_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evt_fifo_push_scheduler.sv
// Bench for evt_fifo_push_scheduler: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of arbitration and power sequencing.
module tb_evt_fifo_push_scheduler;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [N-1:0]          valid;
  logic [N-1:0][DW-1:0]  data;
  logic [N-1:0]          ready;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic [DW-1:0]         fdata;
  logic                  sleep;
  logic [1:0]            gidx;

  int total = 0;
  int bad   = 0;

  // model: mode 0 = active, 1 = sleeping, 2 = waking
  int m_ptr, m_idle, m_mode, m_wake_left;

  evt_fifo_push_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(valid), .req_data_i(data), .req_ready_o(ready),
    .fifo_full_i(full), .fifo_empty_i(empty),
    .fifo_push_o(push), .fifo_data_o(fdata),
    .power_sleep_o(sleep), .grant_idx_o(gidx)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (m_mode != 0 || full) return -1;
    for (int k = 0; k < N; k++) begin
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clock();
    int g;
    g = exp_grant();
    if (g >= 0) m_ptr = (g + 1) % N;
    if (flush) begin
      m_ptr  = 0;
      m_idle = 0;
      if (m_mode == 2) m_wake_left = WAKE;
    end else if (m_mode == 0) begin
      if (valid == '0 && empty) begin
        m_idle++;
        if (m_idle == IDLE) begin m_mode = 1; m_idle = 0; end
      end else m_idle = 0;
    end else if (m_mode == 1) begin
      if (valid != '0 || !empty) begin m_mode = 2; m_wake_left = WAKE; end
    end else begin
      m_wake_left--;
      if (m_wake_left == 0) m_mode = 0;
    end
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_idle = 0; m_mode = 0; m_wake_left = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; valid = '0; full = 1'b0; empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; full = 1'b0; empty = 1'b0; valid = '1;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    for (int r = 0; r < 2; r++) begin
      #2;
      total++; if (ready !== '0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
      total++; if (push !== 1'b0) begin bad++; $display("FAIL rst_push got=%b exp=0", push); end
      total++; if (fdata !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", fdata); end
      total++; if (gidx !== '0) begin bad++; $display("FAIL rst_gidx got=%0d exp=0", gidx); end
      total++; if (sleep !== 1'b0) begin bad++; $display("FAIL rst_sleep got=%b exp=0", sleep); end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    valid = '0; empty = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] er;
    do_reset();
    valid = '1; empty = 1'b0;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    for (int k = 0; k < 5; k++) begin
      #2;
      er = N'(1) << (k % N);
      total++; if (gidx !== 2'(k % N)) begin bad++; $display("FAIL rr_gidx step=%0d got=%0d exp=%0d", k, gidx, k % N); end
      total++; if (ready !== er) begin bad++; $display("FAIL rr_ready step=%0d got=%b exp=%b", k, ready, er); end
      total++; if (fdata !== data[k % N]) begin bad++; $display("FAIL rr_data step=%0d got=%h exp=%h", k, fdata, data[k % N]); end
      cycle();
    end
  endtask

  task automatic test_sparse();
    int exp_seq[3] = '{3, 1, 3};
    valid = 4'b0010;
    #2;
    total++; if (gidx !== 2'd1) begin bad++; $display("FAIL sp_setup got=%0d exp=1", gidx); end
    cycle();
    valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #2;
      total++; if (gidx !== 2'(exp_seq[k])) begin bad++; $display("FAIL sp_gidx step=%0d got=%0d exp=%0d", k, gidx, exp_seq[k]); end
      total++; if (fdata !== data[exp_seq[k]]) begin bad++; $display("FAIL sp_data step=%0d got=%h exp=%h", k, fdata, data[exp_seq[k]]); end
      cycle();
    end
  endtask

  task automatic test_full();
    valid = 4'b0010;
    #2;
    cycle();
    valid = '1; full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      total++; if (ready !== '0) begin bad++; $display("FAIL full_ready step=%0d got=%b exp=0", k, ready); end
      total++; if (push !== 1'b0) begin bad++; $display("FAIL full_push step=%0d got=%b exp=0", k, push); end
      total++; if (fdata !== '0) begin bad++; $display("FAIL full_data step=%0d got=%h exp=0", k, fdata); end
      cycle();
    end
    full = 1'b0;
    #2;
    total++; if (gidx !== 2'd2) begin bad++; $display("FAIL full_resume_gidx got=%0d exp=2", gidx); end
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL full_resume_ready got=%b exp=0100", ready); end
    cycle();
    valid = '0;
  endtask

  task automatic test_sleep();
    do_reset();
    for (int c = 1; c <= IDLE; c++) begin
      #2;
      total++; if (sleep !== 1'b0) begin bad++; $display("FAIL sl_early cyc=%0d got=%b exp=0", c, sleep); end
      cycle();
    end
    #2;
    total++; if (sleep !== 1'b1) begin bad++; $display("FAIL sl_assert got=%b exp=1", sleep); end
    valid = 4'b0100;
    #1;
    total++; if (ready !== '0) begin bad++; $display("FAIL sl_noready got=%b exp=0", ready); end
    cycle();
    for (int w = 0; w < WAKE; w++) begin
      #2;
      total++; if (sleep !== 1'b0) begin bad++; $display("FAIL sl_wake_sleep w=%0d got=%b exp=0", w, sleep); end
      total++; if (push !== 1'b0) begin bad++; $display("FAIL sl_wake_push w=%0d got=%b exp=0", w, push); end
      cycle();
    end
    #2;
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL sl_grant_ready got=%b exp=0100", ready); end
    total++; if (fdata !== data[2]) begin bad++; $display("FAIL sl_grant_data got=%h exp=%h", fdata, data[2]); end
    cycle();
    valid = '0;
  endtask

  task automatic test_flush();
    valid = 4'b0100; empty = 1'b1;
    #2;
    total++; if (gidx !== 2'd2) begin bad++; $display("FAIL fl_setup got=%0d exp=2", gidx); end
    cycle();
    valid = '0;
    for (int c = 0; c < 10; c++) begin #2; cycle(); end
    flush = 1'b1;
    #2;
    cycle();
    flush = 1'b0;
    for (int c = 1; c <= IDLE; c++) begin
      #2;
      total++; if (sleep !== 1'b0) begin bad++; $display("FAIL fl_fresh cyc=%0d got=%b exp=0", c, sleep); end
      cycle();
    end
    #2;
    total++; if (sleep !== 1'b1) begin bad++; $display("FAIL fl_sleep got=%b exp=1", sleep); end
    valid = '1;
    for (int c = 0; c <= WAKE; c++) begin
      #2;
      total++; if (push !== 1'b0) begin bad++; $display("FAIL fl_wake_push c=%0d got=%b exp=0", c, push); end
      cycle();
    end
    #2;
    total++; if (gidx !== 2'd0) begin bad++; $display("FAIL fl_ptr got=%0d exp=0", gidx); end
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL fl_ready got=%b exp=0001", ready); end
    cycle();
    valid = '0;
  endtask

  task automatic test_reset_wake();
    valid = '0; empty = 1'b1;
    for (int c = 0; c < IDLE; c++) begin #2; cycle(); end
    #2;
    total++; if (sleep !== 1'b1) begin bad++; $display("FAIL rw_sleep got=%b exp=1", sleep); end
    valid = '1;
    cycle();
    rst_n = 1'b0;
    #1;
    total++; if (ready !== '0) begin bad++; $display("FAIL rw_ready got=%b exp=0", ready); end
    total++; if (push !== 1'b0) begin bad++; $display("FAIL rw_push got=%b exp=0", push); end
    total++; if (fdata !== '0) begin bad++; $display("FAIL rw_data got=%h exp=0", fdata); end
    total++; if (gidx !== '0) begin bad++; $display("FAIL rw_gidx got=%0d exp=0", gidx); end
    total++; if (sleep !== 1'b0) begin bad++; $display("FAIL rw_sleep_rst got=%b exp=0", sleep); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    total++; if (push !== 1'b1) begin bad++; $display("FAIL rw_release_push got=%b exp=1", push); end
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL rw_release_ready got=%b exp=0001", ready); end
    total++; if (sleep !== 1'b0) begin bad++; $display("FAIL rw_release_sleep got=%b exp=0", sleep); end
    cycle();
    valid = '0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] er;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((cyc % 50) < 22) begin
        valid = '0; empty = 1'b1; full = ($urandom_range(0, 3) == 0);
      end else begin
        valid = N'($urandom); full = ($urandom_range(0, 3) == 0); empty = $urandom_range(0, 1) != 0;
      end
      flush = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++) data[i] = $urandom;
      #2;
      g  = exp_grant();
      er = (g >= 0) ? (N'(1) << g) : '0;
      total++; if (ready !== er) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready, er); end
      total++; if (push !== (g >= 0)) begin bad++; $display("FAIL rnd_push cyc=%0d got=%b exp=%0d", cyc, push, g >= 0); end
      total++; if (gidx !== ((g >= 0) ? 2'(g) : 2'd0)) begin bad++; $display("FAIL rnd_gidx cyc=%0d got=%0d exp=%0d", cyc, gidx, g); end
      total++; if (fdata !== ((g >= 0) ? data[g] : '0)) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h", cyc, fdata); end
      total++; if (sleep !== (m_mode == 1)) begin bad++; $display("FAIL rnd_sleep cyc=%0d got=%b exp=%0d", cyc, sleep, m_mode == 1); end
      cycle();
    end
    flush = 1'b0; valid = '0; full = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = '0; data = '0; full = 1'b0; empty = 1'b1;
    model_reset();
    #1;
    test_reset();
    test_round_robin();
    test_sparse();
    test_full();
    test_sleep();
    test_flush();
    test_reset_wake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
